iro_sequencer: RTL
==================

Name: iro_sequencer

Overview:
- Synchronous controller that runs one measurement of the instrumented ring oscillator per `start` command.
- Sequence: serially loads the 25-bit seed over the bclk/bdat interface, waits for the seed to settle, then enables the ring for a programmed number of clock cycles and counts edges on phase 0.
- It then freezes the ring with `hold` and captures a synchronized snapshot of the 16 phase taps.
- Sits between the host register/command logic and the ring oscillator; it is the only driver of the oscillator's control inputs.

Parameters:
- N_STAGES, 25, seed length in bits and number of shift pulses.
- SETTLE_CYCLES, 4, clk cycles with enable low after the seed load.
- HOLD_CYCLES, 8, clk cycles with hold high before capture (minimum 3).
- SYNC_STAGES, 2, flop depth of the phase synchronizer (minimum 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- abort  in  1  return to IDLE from any state
- cfg_seed  in  N_STAGES  seed value, latched at start
- cfg_n_stages  in  4  ring length select, latched at start
- cfg_run_cycles  in  16  RUN duration in clk cycles, latched at start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes normally
- result_phases  out  16  synchronized phase snapshot
- result_edges  out  16  rising edges seen on phase 0 during RUN
- iro_enable  out  1  ring enable
- iro_hold  out  1  ring hold
- iro_bclk  out  1  seed shift clock
- iro_bdat  out  1  seed shift data
- iro_n_stages  out  4  ring length select to the oscillator
- iro_phases  in  16  asynchronous phase taps from the oscillator

Behaviour:

Reset:
- All outputs are 0, state is IDLE, and the latched configuration, result_phases and result_edges clear to 0.
- Reset mid-operation aborts immediately and asynchronously.

All oscillator outputs are registered, so they are glitch-free.

States:
- IDLE -> SHIFT -> SETTLE -> RUN -> HOLD -> DONE -> IDLE.
- IDLE:
  - iro_enable, iro_hold and iro_bclk are 0.
  - start=1 latches the cfg_* inputs, clears result_edges, and moves to SHIFT on the next cycle.
- SHIFT:
  - 2*N_STAGES cycles; bits are sent MSB first, cfg_seed[N_STAGES-1] first.
  - Bit i uses two cycles: cycle 2i has bclk=0 and bdat=bit; cycle 2i+1 has bclk=1 with bdat unchanged.
  - After the last high phase, bclk returns to 0 and bdat to 0.
- SETTLE: enable=0 for SETTLE_CYCLES cycles.
- RUN:
  - enable=1 for R = max(cfg_run_cycles, 1) cycles; a value of 0 is treated as 1.
  - Each rising edge of synchronized phase bit 0 detected in a RUN cycle increments result_edges.
  - result_edges saturates at 0xFFFF.
- HOLD:
  - enable=1 and hold=1 for HOLD_CYCLES cycles.
  - In the last HOLD cycle, result_phases loads the synchronizer output.
- DONE:
  - One cycle: done=1, busy=1, enable=0, hold=0.
  - Next state is IDLE.

Other rules:
- iro_n_stages drives the latched cfg_n_stages from the cycle after start until the next start; it is not changed by DONE.
- Synchronizer: all 16 iro_phases bits pass through SYNC_STAGES flops. The edge detector compares the last stage with one extra flop.
- Latency: if start is sampled at edge k, done is high in the cycle beginning at edge k+1+2*N_STAGES+SETTLE_CYCLES+R+HOLD_CYCLES. With defaults and R=100 this is k+163.
- start while busy is ignored, with no effect on the latched configuration.
- start and abort together in IDLE: abort wins and state stays IDLE.
- abort in any non-IDLE state:
  - Next cycle is IDLE with enable, hold, bclk and bdat at 0; done is not pulsed.
  - result_phases keeps its previous value; result_edges keeps its partial count.
- The results stay stable from DONE until the next accepted start.

Test Plan:
- Reset, then start with cfg_seed=0x1A5A5A5, R=10 -> exactly 25 bclk rising edges, bdat bit sequence 1,1,0,1,0,0,1,0,1,... (MSB first), and a bench shift-register model ends equal to 0x1A5A5A5.
- Ring stub toggles phase 0 every 5 clk while enabled; R=100, defaults -> done at k+163, result_edges=10 (±1 for synchronizer alignment, bench checks the exact model value), busy low at k+164.
- Ring stub drives phases=0xBEEF constant while hold=1 -> result_phases=0xBEEF at done; iro_hold high for exactly 8 cycles; iro_enable low in the DONE cycle.
- cfg_run_cycles=0 -> RUN lasts 1 cycle and done arrives at k+64. A second start pulse during SHIFT is ignored: the shifted seed is unchanged and only one done pulse occurs.
- abort asserted in RUN at cycle 20 -> next cycle IDLE, enable=0, no done pulse, result_edges holds the partial count; a subsequent start runs normally.
- rst_n pulsed low during SHIFT bit 7 -> all outputs 0 immediately and results cleared; after release, start produces the full 25-bit sequence from the first bit.

Source files
------------

// File: rtl/iro_sequencer.sv
// Measurement sequencer for the instrumented ring oscillator: seed shift-in, settle,
// timed run with phase-0 edge counting, hold and synchronized phase capture.
module iro_sequencer #(
  parameter int N_STAGES      = 25,
  parameter int SETTLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [N_STAGES-1:0] cfg_seed,
  input  logic [3:0]          cfg_n_stages,
  input  logic [15:0]         cfg_run_cycles,
  output logic                busy,
  output logic                done,
  output logic [15:0]         result_phases,
  output logic [15:0]         result_edges,
  output logic                iro_enable,
  output logic                iro_hold,
  output logic                iro_bclk,
  output logic                iro_bdat,
  output logic [3:0]          iro_n_stages,
  input  logic [15:0]         iro_phases
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_SETTLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [15:0] SHIFT_LAST  = 16'(2 * N_STAGES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

  state_t                r_state;
  logic [15:0]           r_cnt;
  logic [15:0]           r_run_last;
  logic [N_STAGES-1:0]   r_sh;
  logic [3:0]            r_nst;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_en;
  logic                  r_hold;
  logic                  r_run;
  logic                  r_bclk;
  logic                  r_bdat;
  logic [15:0]           r_phases;
  logic [15:0]           r_edges;
  logic [15:0]           r_sync [SYNC_STAGES];
  logic                  r_prev0;

  logic [15:0]           w_sync;
  logic                  w_rise;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync[0] & ~r_prev0;

  assign busy          = r_busy;
  assign done          = r_done;
  assign result_phases = r_phases;
  assign result_edges  = r_edges;
  assign iro_enable    = r_en;
  assign iro_hold      = r_hold;
  assign iro_bclk      = r_bclk;
  assign iro_bdat      = r_bdat;
  assign iro_n_stages  = r_nst;

  // Phase synchronizer; only bit 0 gets the extra flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev0 <= 1'b0;
    end else begin
      r_sync[0] <= iro_phases;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev0 <= w_sync[0];
    end
  end

  // Oscillator pins are registered from the current state, so each state's
  // pin pattern appears one cycle after the state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_run_last <= '0;
      r_sh       <= '0;
      r_nst      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_en       <= 1'b0;
      r_hold     <= 1'b0;
      r_run      <= 1'b0;
      r_bclk     <= 1'b0;
      r_bdat     <= 1'b0;
      r_phases   <= '0;
      r_edges    <= '0;
    end else begin
      r_busy <= (r_state != S_IDLE);
      r_done <= (r_state == S_DONE);
      r_en   <= (r_state == S_RUN) || (r_state == S_HOLD);
      r_hold <= (r_state == S_HOLD);
      r_run  <= (r_state == S_RUN);
      r_bclk <= (r_state == S_SHIFT) && r_cnt[0];
      r_bdat <= (r_state == S_SHIFT) && r_sh[N_STAGES-1];

      if (r_run && w_rise && (r_edges != 16'hFFFF))
        r_edges <= r_edges + 16'd1;

      if (abort) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_en    <= 1'b0;
        r_hold  <= 1'b0;
        r_run   <= 1'b0;
        r_bclk  <= 1'b0;
        r_bdat  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            // r_busy still covers the DONE pin cycle, so start is ignored there.
            if (start && !r_busy) begin
              r_sh       <= cfg_seed;
              r_nst      <= cfg_n_stages;
              r_run_last <= (cfg_run_cycles == 16'd0) ? 16'd0 : cfg_run_cycles - 16'd1;
              r_edges    <= '0;
              r_cnt      <= '0;
              r_state    <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (r_cnt[0]) r_sh <= {r_sh[N_STAGES-2:0], 1'b0};
            if (r_cnt == SHIFT_LAST) begin
              r_cnt   <= '0;
              r_state <= S_SETTLE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
              r_cnt   <= '0;
              r_state <= S_RUN;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_RUN: begin
            if (r_cnt == r_run_last) begin
              r_cnt   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
              r_cnt   <= '0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_DONE: begin
            // Pins are showing the last HOLD cycle here.
            r_phases <= w_sync;
            r_state  <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
